present_stream_ctrl: RTL and testbench
======================================

Name: present_stream_ctrl

Overview:
- Upstream/downstream sequencer for the PRESENT core.
- Accepts a 32-bit valid/ready word stream and packs each pair of words into a 64-bit block.
- Drives the core's load/data/key/control inputs, waits for the core's done pulse, captures the 64-bit result and returns it as two 32-bit output words.
- Sits between the VexRiscv peripheral bus glue and the PRESENT core; adds a done-timeout watchdog and a processed-block counter.

Parameters:
- TIMEOUT, 255, max cycles in WAIT without core_done before abort (must be >= 1).
- CNT_W, 16, width of the processed-block counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- iReset  input  1  asynchronous, active-high reset
- key_in  input  80  cipher key, sampled in LOAD
- mode  input  1  0=encrypt, 1=decrypt, sampled in LOAD
- s_valid  input  1  input word valid
- s_ready  output  1  input word accepted when s_valid&s_ready
- s_data  input  32  input word; first word of a block = bits[63:32], second = bits[31:0]
- m_valid  output  1  output word valid
- m_ready  input  1  output word consumed when m_valid&m_ready
- m_data  output  32  output word; first = result[63:32], second = result[31:0]
- core_idat  output  64  block to core (held stable from LOAD until next LOAD)
- core_key  output  80  key to core (held as core_idat)
- core_load  output  1  one-cycle load pulse to core
- core_control  output  1  mode to core (held as core_idat)
- core_odat  input  64  core result
- core_done  input  1  core completion pulse; core_odat valid in that cycle
- busy  output  1  high in any state other than W0
- err  output  1  sticky timeout flag
- blk_count  output  CNT_W  number of blocks whose result was fully consumed

Behaviour:
- Reset (async, iReset=1):
  - State W0.
  - s_ready=0 during reset, then 1 from the first cycle in W0.
  - m_valid=0, m_data=0, core_load=0, core_idat=0, core_key=0, core_control=0, busy=0, err=0, blk_count=0, internal result/timeout regs=0.
  - Reset mid-operation aborts everything; any in-flight core_done after reset is ignored.
- States:
  - W0: s_ready=1; on handshake latch s_data into hi half -> W1.
  - W1: s_ready=1; on handshake latch lo half -> LOAD.
  - LOAD: core_load=1 for exactly this cycle. core_idat/core_key/core_control update from the packed block, key_in and mode on the edge entering LOAD, so they are stable during the pulse. Timeout counter cleared. Next state WAIT.
  - WAIT: s_ready=0.
    - On core_done=1, register core_odat -> OUT0.
    - Otherwise increment the timeout counter; when it reaches TIMEOUT, set err=1 and go to W0, discarding the block.
    - core_done in the same cycle as the counter reaching TIMEOUT: done wins, err is not set.
  - OUT0: m_valid=1, m_data=result[63:32]; on m_ready -> OUT1.
  - OUT1: m_valid=1, m_data=result[31:0]; on m_ready -> W0, blk_count += 1 (wraps modulo 2^CNT_W).
- Handshake rules:
  - m_data and m_valid are held stable while m_valid=1 and m_ready=0 (backpressure of any length).
  - s_ready=0 in LOAD, WAIT, OUT0 and OUT1.
- core_done is ignored in every state except WAIT.
- core_load is never asserted outside LOAD.
- err clears only on reset.
- Minimum latency (core excluded):
  - 2nd input handshake at edge k -> core_load high in cycle k+1.
  - core_done at edge j -> m_valid high from cycle j+1.
- Outputs are registered except s_ready, m_valid and busy, which decode the state register.

Test Plan:
- Key 0, mode 0, words 00000000,00000000 with a real core attached -> m_data 5579C138 then 7B228445; blk_count=1; err=0.
- Key all-F, mode 0, pt 0 -> E72C46C0, F5945049; then mode 1 with those two words -> 00000000, 00000000; blk_count=2.
- Key 0, mode 0, pt FFFFFFFF,FFFFFFFF with m_ready held 0 for 20 cycles -> m_valid stays 1, m_data stays A112FFC7 throughout; then A112FFC7, 2F68417B; s_ready stays 0 until the second output is consumed.
- Stub core that never raises core_done, TIMEOUT=8 -> err=1 exactly 8 WAIT cycles after LOAD, state back in W0 (s_ready=1), no m_valid, blk_count unchanged.
- Stub raises core_done in a W0 cycle and again on the exact timeout cycle -> first ignored; second captured with err=0 and output produced.
- Assert iReset while in WAIT, release, then issue key all-F, pt all-F -> all outputs at reset values during reset; afterwards 3333DCD3, 213210D2 and blk_count=1.

Source files
------------

// File: rtl/present_stream_ctrl.sv
// Purpose : packs 32-bit stream word pairs into 64-bit PRESENT blocks, sequences the core, unpacks results.
// Latency : 2nd input handshake -> core_load next cycle; core_done -> m_valid next cycle.
// Backpressure: s_ready drops from LOAD until the second result word is taken; m_valid/m_data hold under m_ready=0.
//
// Ports:
//   clk, iReset                    clock and asynchronous active-high reset
//   key_in, mode                   key and direction, sampled on the edge entering LOAD
//   s_valid/s_ready/s_data         32-bit input word stream (hi word first)
//   m_valid/m_ready/m_data         32-bit output word stream (hi word first)
//   core_idat/core_key/core_control/core_load   block, key, mode and load pulse to the core
//   core_odat/core_done            core result and its completion pulse
//   busy, err, blk_count           status: not idle, sticky timeout, completed-block counter
module present_stream_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             iReset,
   input  logic [79:0]      key_in,
   input  logic             mode,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [31:0]      s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [31:0]      m_data,
   output logic [63:0]      core_idat,
   output logic [79:0]      core_key,
   output logic             core_load,
   output logic             core_control,
   input  logic [63:0]      core_odat,
   input  logic             core_done,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] blk_count
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_MAX = TIMEOUT[TW-1:0];

   typedef enum logic [2:0] {
      ST_W0,
      ST_W1,
      ST_LOAD,
      ST_WAIT,
      ST_OUT0,
      ST_OUT1
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [31:0]      r_hi;
   logic [31:0]      r_res_lo;
   logic [TW-1:0]    r_tmo;
   logic [31:0]      r_m_data;
   logic [63:0]      r_core_idat;
   logic [79:0]      r_core_key;
   logic             r_core_control;
   logic             r_core_load;
   logic             r_err;
   logic [CNT_W-1:0] r_blk_count;

   logic             w_s_ready;
   logic             w_m_valid;
   logic             w_busy;
   logic [TW-1:0]    w_tmo_nxt;
   logic             w_tmo_hit;

   assign w_tmo_nxt = r_tmo + 1'b1;
   // A done pulse on the final allowed cycle takes priority over the abort.
   assign w_tmo_hit = (r_state == ST_WAIT) && !core_done && (w_tmo_nxt == TMO_MAX);

   always_comb begin
      w_next    = r_state;
      w_s_ready = 1'b0;
      w_m_valid = 1'b0;
      w_busy    = 1'b1;
      case (r_state)
         ST_W0: begin
            w_busy    = 1'b0;
            w_s_ready = 1'b1;
            if (s_valid) w_next = ST_W1;
         end
         ST_W1: begin
            w_s_ready = 1'b1;
            if (s_valid) w_next = ST_LOAD;
         end
         ST_LOAD: w_next = ST_WAIT;
         ST_WAIT: begin
            if (core_done)      w_next = ST_OUT0;
            else if (w_tmo_hit) w_next = ST_W0;
         end
         ST_OUT0: begin
            w_m_valid = 1'b1;
            if (m_ready) w_next = ST_OUT1;
         end
         ST_OUT1: begin
            w_m_valid = 1'b1;
            if (m_ready) w_next = ST_W0;
         end
         default: w_next = ST_W0;
      endcase
   end

   always_ff @(posedge clk or posedge iReset) begin
      if (iReset) r_state <= ST_W0;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or posedge iReset) begin
      if (iReset) begin
         r_hi           <= '0;
         r_res_lo       <= '0;
         r_tmo          <= '0;
         r_m_data       <= '0;
         r_core_idat    <= '0;
         r_core_key     <= '0;
         r_core_control <= 1'b0;
         r_core_load    <= 1'b0;
         r_err          <= 1'b0;
         r_blk_count    <= '0;
      end else begin
         // Registered so the pulse lines up with the cycle spent in LOAD.
         r_core_load <= (r_state == ST_W1) && s_valid;
         if ((r_state == ST_W0) && s_valid) r_hi <= s_data;
         if ((r_state == ST_W1) && s_valid) begin
            r_core_idat    <= {r_hi, s_data};
            r_core_key     <= key_in;
            r_core_control <= mode;
         end
         if (r_state == ST_LOAD)                   r_tmo <= '0;
         else if ((r_state == ST_WAIT) && !core_done) r_tmo <= w_tmo_nxt;
         if (w_tmo_hit) r_err <= 1'b1;
         if ((r_state == ST_WAIT) && core_done) begin
            r_res_lo <= core_odat[31:0];
            r_m_data <= core_odat[63:32];
         end
         if ((r_state == ST_OUT0) && m_ready) r_m_data <= r_res_lo;
         if ((r_state == ST_OUT1) && m_ready) r_blk_count <= r_blk_count + 1'b1;
      end
   end

   // s_ready is forced low while reset is held, even though the state already reads W0.
   assign s_ready      = w_s_ready & ~iReset;
   assign m_valid      = w_m_valid;
   assign busy         = w_busy;
   assign m_data       = r_m_data;
   assign core_idat    = r_core_idat;
   assign core_key     = r_core_key;
   assign core_control = r_core_control;
   assign core_load    = r_core_load;
   assign err          = r_err;
   assign blk_count    = r_blk_count;

endmodule

// File: tb/tb_present_stream_ctrl.sv
// Purpose : self-checking bench for present_stream_ctrl; the bench itself plays the PRESENT core.
// Latency : core response delay chosen per block (1..TIMEOUT WAIT cycles) or withheld for the abort case.
// Backpressure: m_ready is stalled randomly and for fixed stretches.
module tb_present_stream_ctrl;

   localparam int TMO = 8;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          iReset;
   logic [79:0]   key_in;
   logic          mode;
   logic          s_valid;
   logic          s_ready;
   logic [31:0]   s_data;
   logic          m_valid;
   logic          m_ready;
   logic [31:0]   m_data;
   logic [63:0]   core_idat;
   logic [79:0]   core_key;
   logic          core_load;
   logic          core_control;
   logic [63:0]   core_odat;
   logic          core_done;
   logic          busy;
   logic          err;
   logic [CW-1:0] blk_count;

   int n_pass  = 0;
   int n_total = 0;
   int exp_cnt = 0;

   typedef struct packed {
      logic [63:0] idat;
      logic [79:0] key;
      logic        ctl;
      logic        load_ok;
      logic        done_ok;
      logic        hold_ok;
      logic        drained;
      logic [31:0] w0;
      logic [31:0] w1;
   } blk_obs_t;

   present_stream_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .iReset(iReset), .key_in(key_in), .mode(mode),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .core_idat(core_idat), .core_key(core_key), .core_load(core_load),
      .core_control(core_control), .core_odat(core_odat), .core_done(core_done),
      .busy(busy), .err(err), .blk_count(blk_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- PRESENT-80 reference ----------------
   function automatic logic [3:0] sb(input logic [3:0] x);
      case (x)
         4'h0: sb = 4'hC; 4'h1: sb = 4'h5; 4'h2: sb = 4'h6; 4'h3: sb = 4'hB;
         4'h4: sb = 4'h9; 4'h5: sb = 4'h0; 4'h6: sb = 4'hA; 4'h7: sb = 4'hD;
         4'h8: sb = 4'h3; 4'h9: sb = 4'hE; 4'hA: sb = 4'hF; 4'hB: sb = 4'h8;
         4'hC: sb = 4'h4; 4'hD: sb = 4'h7; 4'hE: sb = 4'h1; default: sb = 4'h2;
      endcase
   endfunction

   function automatic logic [3:0] sbi(input logic [3:0] y);
      sbi = 4'h0;
      for (int v = 0; v < 16; v++) if (sb(4'(v)) == y) sbi = 4'(v);
   endfunction

   function automatic int pbit(input int b);
      pbit = (b == 63) ? 63 : (b * 16) % 63;
   endfunction

   function automatic logic [63:0] present_crypt(input logic [63:0] din, input logic [79:0] key, input logic dec);
      logic [63:0] rk [32];
      logic [79:0] k;
      logic [63:0] s;
      logic [63:0] t;
      k = key;
      for (int r = 0; r < 32; r++) begin
         rk[r]     = k[79:16];
         k         = {k[18:0], k[79:19]};
         k[79:76]  = sb(k[79:76]);
         k[19:15]  = k[19:15] ^ 5'(r + 1);
      end
      if (!dec) begin
         s = din;
         for (int r = 0; r < 31; r++) begin
            s = s ^ rk[r];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sb(s[4*n +: 4]);
            t = '0;
            for (int b = 0; b < 64; b++) t[pbit(b)] = s[b];
            s = t;
         end
         s = s ^ rk[31];
      end else begin
         s = din ^ rk[31];
         for (int r = 30; r >= 0; r--) begin
            t = '0;
            for (int b = 0; b < 64; b++) t[b] = s[pbit(b)];
            s = t;
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sbi(s[4*n +: 4]);
            s = s ^ rk[r];
         end
      end
      present_crypt = s;
   endfunction

   // ---------------- stimulus drivers (return observations only) ----------------
   task automatic send_word(input logic [31:0] w, output logic ok);
      ok      = 1'b0;
      s_valid = 1'b1;
      s_data  = w;
      for (int c = 0; c < 50; c++) begin
         if (s_ready) begin
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_data  = $urandom;
   endtask

   // Pushes one block, answers as the core after 'lat' WAIT cycles, drains both words.
   task automatic run_block(input logic [79:0] k, input logic md, input logic [63:0] pt,
                            input int lat, input int stall0, input int stall_max,
                            output blk_obs_t o);
      logic        ok1, ok2, have_prev;
      logic [31:0] prev;
      int          idx;
      o        = '0;
      o.hold_ok = 1'b1;
      key_in   = k;
      mode     = md;
      send_word(pt[63:32], ok1);
      send_word(pt[31:0], ok2);
      o.load_ok = ok1 && ok2 && (core_load === 1'b1);
      o.idat    = core_idat;
      o.key     = core_key;
      o.ctl     = core_control;
      key_in    = ~k;
      mode      = ~md;
      for (int c = 0; c < lat; c++) @(negedge clk);
      if (core_load !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0 ||
          core_idat !== o.idat || core_key !== o.key || core_control !== o.ctl) o.hold_ok = 1'b0;
      core_done = 1'b1;
      core_odat = present_crypt(core_idat, core_key, core_control);
      @(negedge clk);
      core_done = 1'b0;
      core_odat = {$urandom, $urandom};
      o.done_ok = (m_valid === 1'b1);
      idx       = 0;
      have_prev = 1'b0;
      prev      = '0;
      for (int c = 0; c < 400 && idx < 2; c++) begin
         if (m_valid !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) o.hold_ok = 1'b0;
         if (have_prev && m_data !== prev) o.hold_ok = 1'b0;
         prev      = m_data;
         have_prev = 1'b1;
         m_ready   = (c >= stall0) && ($urandom_range(0, stall_max) == 0);
         if (m_ready) begin
            if (idx == 0) o.w0 = m_data;
            else          o.w1 = m_data;
            idx++;
            have_prev = 1'b0;
         end
         @(negedge clk);
         m_ready = 1'b0;
      end
      o.drained = (idx == 2);
      if (o.drained) exp_cnt = (exp_cnt + 1) % (1 << CW);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      iReset = 1'b1; key_in = '0; mode = 1'b0; s_valid = 1'b0; s_data = '0;
      m_ready = 1'b0; core_odat = '0; core_done = 1'b0;
      #1;
      n_total++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %b exp 0", s_ready); else n_pass++;
      n_total++; if ({m_valid, core_load, busy, err} !== 4'b0) $display("FAIL rst_flags got %b exp 0000", {m_valid, core_load, busy, err}); else n_pass++;
      n_total++; if ({m_data, core_idat, core_key, core_control, blk_count} !== '0) $display("FAIL rst_data got %h exp 0", {m_data, core_idat, core_key, core_control, blk_count}); else n_pass++;
      @(negedge clk); @(negedge clk);
      iReset = 1'b0;
      @(negedge clk);
      n_total++; if ({s_ready, busy} !== 2'b10) $display("FAIL idle_after_rst got %b exp 10", {s_ready, busy}); else n_pass++;
   endtask

   task automatic test_directed;
      blk_obs_t o;
      run_block(80'h0, 1'b0, 64'h0, 3, 0, 0, o);
      n_total++; if ({o.w0, o.w1} !== 64'h5579C1387B228445) $display("FAIL dir_k0_p0 got %h exp 5579C1387B228445", {o.w0, o.w1}); else n_pass++;
      n_total++; if ({o.load_ok, o.done_ok, o.hold_ok, o.drained} !== 4'hF) $display("FAIL dir_k0_flow got %b exp 1111", {o.load_ok, o.done_ok, o.hold_ok, o.drained}); else n_pass++;
      n_total++; if (blk_count !== CW'(exp_cnt) || err !== 1'b0) $display("FAIL dir_k0_cnt got %0d/%b exp %0d/0", blk_count, err, exp_cnt); else n_pass++;
      run_block({80{1'b1}}, 1'b0, 64'h0, 5, 0, 1, o);
      n_total++; if ({o.w0, o.w1} !== 64'hE72C46C0F5945049) $display("FAIL dir_kf_enc got %h exp E72C46C0F5945049", {o.w0, o.w1}); else n_pass++;
      run_block({80{1'b1}}, 1'b1, 64'hE72C46C0F5945049, 2, 0, 1, o);
      n_total++; if ({o.w0, o.w1} !== 64'h0) $display("FAIL dir_kf_dec got %h exp 0", {o.w0, o.w1}); else n_pass++;
      n_total++; if (o.ctl !== 1'b1 || o.idat !== 64'hE72C46C0F5945049) $display("FAIL dir_dec_core got %b/%h exp 1/E72C46C0F5945049", o.ctl, o.idat); else n_pass++;
      n_total++; if (blk_count !== CW'(exp_cnt)) $display("FAIL dir_cnt got %0d exp %0d", blk_count, exp_cnt); else n_pass++;
   endtask

   task automatic test_backpressure;
      blk_obs_t o;
      run_block(80'h0, 1'b0, {64{1'b1}}, 4, 20, 2, o);
      n_total++; if ({o.w0, o.w1} !== 64'hA112FFC72F68417B) $display("FAIL bp_words got %h exp A112FFC72F68417B", {o.w0, o.w1}); else n_pass++;
      n_total++; if (o.hold_ok !== 1'b1 || o.drained !== 1'b1) $display("FAIL bp_hold got %b%b exp 11", o.hold_ok, o.drained); else n_pass++;
      n_total++; if ({s_ready, m_valid, busy} !== 3'b100) $display("FAIL bp_idle got %b exp 100", {s_ready, m_valid, busy}); else n_pass++;
   endtask

   task automatic test_done_edge;
      blk_obs_t    o;
      logic [63:0] pt;
      core_done = 1'b1;
      core_odat = {$urandom, $urandom};
      @(negedge clk);
      core_done = 1'b0;
      n_total++; if ({m_valid, s_ready, busy} !== 3'b010) $display("FAIL done_in_w0 got %b exp 010", {m_valid, s_ready, busy}); else n_pass++;
      pt = {$urandom, $urandom};
      run_block(80'h0123456789ABCDEF0123, 1'b0, pt, TMO, 0, 1, o);
      n_total++; if ({o.w0, o.w1} !== present_crypt(pt, 80'h0123456789ABCDEF0123, 1'b0)) $display("FAIL done_at_tmo got %h exp %h", {o.w0, o.w1}, present_crypt(pt, 80'h0123456789ABCDEF0123, 1'b0)); else n_pass++;
      n_total++; if (err !== 1'b0 || o.done_ok !== 1'b1) $display("FAIL done_at_tmo_err got err=%b done=%b exp 0/1", err, o.done_ok); else n_pass++;
   endtask

   task automatic test_random;
      blk_obs_t    o;
      logic [79:0] k;
      logic [63:0] pt;
      logic        md;
      for (int i = 0; i < 20; i++) begin
         k  = {$urandom, $urandom, $urandom};
         pt = {$urandom, $urandom};
         md = 1'($urandom_range(0, 1));
         run_block(k, md, pt, $urandom_range(1, TMO), $urandom_range(0, 3), 3, o);
         n_total++; if ({o.w0, o.w1} !== present_crypt(pt, k, md)) $display("FAIL rnd%0d_words got %h exp %h", i, {o.w0, o.w1}, present_crypt(pt, k, md)); else n_pass++;
         n_total++; if ({o.idat, o.key, o.ctl} !== {pt, k, md}) $display("FAIL rnd%0d_core got %h exp %h", i, {o.idat, o.key, o.ctl}, {pt, k, md}); else n_pass++;
         n_total++; if ({o.load_ok, o.done_ok, o.hold_ok, o.drained} !== 4'hF) $display("FAIL rnd%0d_flow got %b exp 1111", i, {o.load_ok, o.done_ok, o.hold_ok, o.drained}); else n_pass++;
         n_total++; if (blk_count !== CW'(exp_cnt)) $display("FAIL rnd%0d_cnt got %0d exp %0d", i, blk_count, exp_cnt); else n_pass++;
      end
   endtask

   task automatic test_timeout;
      blk_obs_t o;
      logic     ok1, ok2;
      logic     stray;
      key_in = {$urandom, $urandom, $urandom};
      mode   = 1'b0;
      send_word($urandom, ok1);
      send_word($urandom, ok2);
      n_total++; if ((ok1 && ok2 && core_load) !== 1'b1) $display("FAIL tmo_load got %b exp 1", ok1 && ok2 && core_load); else n_pass++;
      stray = 1'b0;
      for (int w = 1; w <= TMO; w++) begin
         @(negedge clk);
         if (core_load !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0) stray = 1'b1;
      end
      n_total++; if (err !== 1'b0 || stray !== 1'b0) $display("FAIL tmo_early got err=%b stray=%b exp 0/0", err, stray); else n_pass++;
      @(negedge clk);
      n_total++; if (err !== 1'b1) $display("FAIL tmo_err got %b exp 1", err); else n_pass++;
      n_total++; if ({s_ready, m_valid, busy} !== 3'b100) $display("FAIL tmo_state got %b exp 100", {s_ready, m_valid, busy}); else n_pass++;
      n_total++; if (blk_count !== CW'(exp_cnt)) $display("FAIL tmo_cnt got %0d exp %0d", blk_count, exp_cnt); else n_pass++;
      run_block(80'h0, 1'b0, 64'h0, 1, 0, 0, o);
      n_total++; if (err !== 1'b1 || {o.w0, o.w1} !== 64'h5579C1387B228445) $display("FAIL err_sticky got err=%b %h exp 1 5579C1387B228445", err, {o.w0, o.w1}); else n_pass++;
   endtask

   task automatic test_reset_mid;
      blk_obs_t o;
      logic     ok1, ok2;
      key_in = '0;
      send_word($urandom, ok1);
      send_word($urandom, ok2);
      @(negedge clk);
      iReset    = 1'b1;
      core_done = 1'b1;
      core_odat = {$urandom, $urandom};
      #1;
      n_total++; if ({s_ready, m_valid, core_load, busy, err} !== 5'b0) $display("FAIL rmid_flags got %b exp 00000", {s_ready, m_valid, core_load, busy, err}); else n_pass++;
      n_total++; if ({m_data, core_idat, core_key, core_control, blk_count} !== '0) $display("FAIL rmid_data got %h exp 0", {m_data, core_idat, core_key, core_control, blk_count}); else n_pass++;
      @(negedge clk); @(negedge clk);
      iReset = 1'b0;
      exp_cnt = 0;
      @(negedge clk);
      core_done = 1'b0;
      n_total++; if ({m_valid, s_ready} !== 2'b01) $display("FAIL rmid_stray_done got %b exp 01", {m_valid, s_ready}); else n_pass++;
      run_block({80{1'b1}}, 1'b0, {64{1'b1}}, 6, 2, 1, o);
      n_total++; if ({o.w0, o.w1} !== 64'h3333DCD3213210D2) $display("FAIL rmid_words got %h exp 3333DCD3213210D2", {o.w0, o.w1}); else n_pass++;
      n_total++; if (blk_count !== CW'(1) || err !== 1'b0) $display("FAIL rmid_cnt got %0d/%b exp 1/0", blk_count, err); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_directed;
      test_backpressure;
      test_done_edge;
      test_random;
      test_timeout;
      test_reset_mid;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
